tx_packet_scheduler: RTL and testbench
======================================

// Module: tx_packet_scheduler
// PURPOSE
//  Shares one 8b/10b serializer lane between NUM_REQ byte-stream requesters.
//  - Grants whole packets of PKT_BYTES data symbols, round-robin.
//  - Inserts K28.5 commas (0xBC, k=1) between packets and whenever the lane idles.
//  - Paces symbols at one per SYM_PERIOD clocks and drives the encoder inputs plus a load strobe.
// PARAMETERS
//  NUM_REQ      4   number of requesters, >=2
//  PKT_BYTES    7   data symbols per packet, >=2
//  IDLE_COMMAS  1   minimum commas between packets, >=1
//  SYM_PERIOD   10  clocks per symbol (one per serialized bit), >=3
// PORTS
//  clk           in   1                clock
//  rst_n         in   1                reset, asynchronous, active-low
//  link_en       in   1                1 = new grants allowed; 0 = commas only
//  req_valid     in   NUM_REQ          requester i has a byte on req_data[8i+:8]
//  req_data      in   8*NUM_REQ        byte from each requester
//  req_ready     out  NUM_REQ          one-cycle pop pulse; byte consumed when valid&&ready
//  sym_data      out  8                encoder data input (registered)
//  sym_k         out  1                encoder K select (registered)
//  sym_load      out  1                one-cycle strobe; encoder latches sym_data/sym_k
//  grant_id      out  $clog2(NUM_REQ)  current/last granted requester
//  busy          out  1                packet in progress
//  pkt_done      out  1                one-cycle pulse when last byte of a packet is sent
//  err_underrun  out  1                one-cycle pulse on packet abort
// BEHAVIOUR
//  Reset (async, rst_n=0) forces the following immediately:
//  - sym_data=0xBC, sym_k=1, sym_load=0, req_ready=0, grant_id=0, busy=0, pkt_done=0,
//    err_underrun=0.
//  - Internal state: slot_cnt=0, byte_cnt=0, gap_cnt=0, rr_ptr=0, state=COMMA.
//  Slot timing:
//  - slot_cnt counts 0..SYM_PERIOD-1 and wraps.
//  - Decision cycle D is slot_cnt==SYM_PERIOD-2. All state, sym_* and grant updates
//    happen only on the D clock edge.
//  - sym_load = (slot_cnt==SYM_PERIOD-1), registered, one cycle after D.
//  - sym_data/sym_k stay stable from D+1 until the next D.
//  - req_ready is combinational. It is asserted only during D and only for the byte being
//    taken, so at most one bit is high.
//  FSM state COMMA (busy=0). At D:
//  - If link_en && |req_valid && gap_cnt>=IDLE_COMMAS: w = first valid index at or after
//    rr_ptr (wrapping). Then grant_id<=w, req_ready[w]=1, sym_data<=req_data[w], sym_k<=0,
//    byte_cnt<=1, state<=PKT.
//  - Else: sym_data<=0xBC, sym_k<=1, gap_cnt<=gap_cnt+1, saturating at IDLE_COMMAS.
//  FSM state PKT (busy=1). At D:
//  - If req_valid[grant_id]: req_ready[grant_id]=1, sym_data<=byte, sym_k<=0,
//    byte_cnt<=byte_cnt+1.
//    - If byte_cnt==PKT_BYTES-1 (last byte): pkt_done pulses, state<=COMMA, gap_cnt<=0,
//      rr_ptr<=grant_id+1 mod NUM_REQ.
//  - Else (underrun): sym_data<=0xBC, sym_k<=1, err_underrun pulses, state<=COMMA,
//    gap_cnt<=1 (the abort comma counts), rr_ptr<=grant_id+1. No partial resume.
//  Boundary rules:
//  - link_en is sampled only in COMMA. Deasserting it mid-packet does not truncate the packet.
//  - req_valid of non-granted requesters is ignored while in PKT.
//  - req_valid changing outside D has no effect.
//  - rr_ptr wraps NUM_REQ-1 -> 0. A lone requester may win consecutively after the
//    IDLE_COMMAS gap.
//  - Reset asserted mid-packet: the packet is dropped, with no further req_ready.
//    After release, IDLE_COMMAS commas are sent before any grant.
//  - Minimum packet-to-packet spacing: IDLE_COMMAS comma symbols exactly, when a request
//    is pending.
// TESTING
//  1 Defaults. Only req 2 valid, constant data 0x5A. Response:
//    - First D after reset: comma. Second D: grant_id=2, busy=1.
//    - 7 data symbols, ready[2] once per symbol.
//    - pkt_done at the 7th, then exactly 1 comma, then a new grant to 2.
//  2 All 4 requesters valid continuously -> grant order 0,1,2,3,0, each packet separated by
//    one 0xBC/k=1 symbol, and exactly 7 req_ready pulses per packet.
//  3 Req 1 granted; req_valid[1] dropped at the D of byte 4 -> sym 0xBC k=1,
//    err_underrun pulses once, busy=0, no ready[1]. Next grant goes to 2 if valid, else wraps.
//  4 link_en=0 with requests pending -> only commas, no req_ready. link_en cleared during
//    byte 3 of a packet -> all 7 bytes still sent, then commas only.
//  5 rst_n pulsed low between clock edges mid-packet -> outputs take reset values without
//    a clock edge. After release: a comma first, grant at the second D.
//  6 IDLE_COMMAS=3 with back-to-back traffic -> exactly 3 commas between every packet pair.
//    sym_load period is always 10 clocks, and sym_data never changes in the sym_load cycle.

Source files
------------

// File: rtl/tx_packet_scheduler_if.sv
// Requester-side and encoder-side signals of the shared serializer lane.
// The scheduler connects through the slave modport.
interface tx_packet_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = $clog2(NUM_REQ);

    logic                 link_en;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           sym_data;
    logic                 sym_k;
    logic                 sym_load;
    logic [IW-1:0]        grant_id;
    logic                 busy;
    logic                 pkt_done;
    logic                 err_underrun;

    modport master (
        output link_en, req_valid, req_data,
        input  req_ready, sym_data, sym_k, sym_load,
        input  grant_id, busy, pkt_done, err_underrun
    );

    modport slave (
        input  link_en, req_valid, req_data,
        output req_ready, sym_data, sym_k, sym_load,
        output grant_id, busy, pkt_done, err_underrun
    );
endinterface

// File: rtl/tx_packet_scheduler.sv
// Round-robin packet scheduler feeding one 8b/10b encoder lane.
// Whole packets are granted; K28.5 commas fill gaps and idle time.
module tx_packet_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int PKT_BYTES   = 7,
    parameter int IDLE_COMMAS = 1,
    parameter int SYM_PERIOD  = 10
) (
    input  logic clk,
    input  logic rst_n,
    tx_packet_scheduler_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(SYM_PERIOD);
    localparam int BW = $clog2(PKT_BYTES + 1);
    localparam int GW = $clog2(IDLE_COMMAS + 1);

    localparam logic [SW-1:0] SLOT_D = SW'(SYM_PERIOD - 2);
    localparam logic [SW-1:0] SLOT_L = SW'(SYM_PERIOD - 1);
    localparam logic [BW-1:0] LAST   = BW'(PKT_BYTES - 1);
    localparam logic [GW-1:0] GAP    = GW'(IDLE_COMMAS);
    localparam logic [7:0]    K28_5  = 8'hBC;

    typedef enum logic {COMMA, PKT} state_t;

    state_t        state, state_n;
    logic [SW-1:0] slot_cnt;
    logic [BW-1:0] byte_cnt, byte_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [IW-1:0] rr_ptr, rr_n;
    logic [IW-1:0] grant_q, grant_n;
    logic [7:0]    sd_q, sd_n;
    logic          sk_q, sk_n;
    logic          load_q;
    logic          done_q, done_n;
    logic          err_q, err_n;

    logic                 dec;
    logic [NUM_REQ-1:0]   rot;
    logic [2*NUM_REQ-1:0] dbl;
    logic                 found;
    logic [IW-1:0]        pick;
    logic [7:0]           pick_byte;
    logic [7:0]           gnt_byte;
    logic                 gnt_valid;
    logic [IW-1:0]        next_ptr;
    logic [NUM_REQ-1:0]   ready;

    assign dec = (slot_cnt == SLOT_D);

    // Symbol slot timer; load strobe trails the decision cycle by one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            load_q   <= 1'b0;
        end else begin
            slot_cnt <= (slot_cnt == SLOT_L) ? '0 : slot_cnt + SW'(1);
            load_q   <= dec;
        end
    end

    // First valid requester at or after rr_ptr, via a rotated request vector
    always_comb begin
        dbl   = {bus.req_valid, bus.req_valid};
        rot   = NUM_REQ'(dbl >> rr_ptr);
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pick  = IW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Byte/valid muxes for the candidate and the current grant
    always_comb begin
        pick_byte = '0;
        gnt_byte  = '0;
        gnt_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick == IW'(k)) begin
                pick_byte = bus.req_data[8*k +: 8];
            end
            if (grant_q == IW'(k)) begin
                gnt_byte  = bus.req_data[8*k +: 8];
                gnt_valid = bus.req_valid[k];
            end
        end
    end

    assign next_ptr = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);

    // Next-state and pop decision, only acted on in the decision cycle
    always_comb begin
        state_n = state;
        byte_n  = byte_cnt;
        gap_n   = gap_cnt;
        rr_n    = rr_ptr;
        grant_n = grant_q;
        sd_n    = sd_q;
        sk_n    = sk_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        ready   = '0;
        if (dec) begin
            unique case (state)
                COMMA: begin
                    if (bus.link_en && found && gap_cnt >= GAP) begin
                        grant_n = pick;
                        ready   = NUM_REQ'(1) << pick;
                        sd_n    = pick_byte;
                        sk_n    = 1'b0;
                        byte_n  = BW'(1);
                        state_n = PKT;
                    end else begin
                        sd_n  = K28_5;
                        sk_n  = 1'b1;
                        gap_n = (gap_cnt >= GAP) ? GAP : gap_cnt + GW'(1);
                    end
                end
                PKT: begin
                    if (gnt_valid) begin
                        ready  = NUM_REQ'(1) << grant_q;
                        sd_n   = gnt_byte;
                        sk_n   = 1'b0;
                        byte_n = byte_cnt + BW'(1);
                        if (byte_cnt == LAST) begin
                            done_n  = 1'b1;
                            state_n = COMMA;
                            gap_n   = '0;
                            rr_n    = next_ptr;
                        end
                    end else begin
                        // Underrun: abort with a comma that counts toward the gap
                        sd_n    = K28_5;
                        sk_n    = 1'b1;
                        err_n   = 1'b1;
                        state_n = COMMA;
                        gap_n   = GW'(1);
                        rr_n    = next_ptr;
                    end
                end
                default: state_n = COMMA;
            endcase
        end
    end

    // State and registered encoder-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COMMA;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            rr_ptr   <= '0;
            grant_q  <= '0;
            sd_q     <= K28_5;
            sk_q     <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            byte_cnt <= byte_n;
            gap_cnt  <= gap_n;
            rr_ptr   <= rr_n;
            grant_q  <= grant_n;
            sd_q     <= sd_n;
            sk_q     <= sk_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.sym_data     = sd_q;
    assign bus.sym_k        = sk_q;
    assign bus.sym_load     = load_q;
    assign bus.grant_id     = grant_q;
    assign bus.busy         = (state == PKT);
    assign bus.pkt_done     = done_q;
    assign bus.err_underrun = err_q;
endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Directed bench for tx_packet_scheduler: one instance with the default
// gap, a second with a three-comma gap running back-to-back traffic.
module tb_tx_packet_scheduler;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_nb;

    tx_packet_scheduler_if #(.NUM_REQ(N)) a ();
    tx_packet_scheduler_if #(.NUM_REQ(N)) b ();

    tx_packet_scheduler #(
        .NUM_REQ(N), .PKT_BYTES(7), .IDLE_COMMAS(1), .SYM_PERIOD(10)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a)
    );

    tx_packet_scheduler #(
        .NUM_REQ(N), .PKT_BYTES(7), .IDLE_COMMAS(3), .SYM_PERIOD(10)
    ) dut_b (
        .clk(clk), .rst_n(rst_nb), .bus(b)
    );

    int errors = 0;
    int checks = 0;

    // Pop counts per requester and multi-hot ready detection on instance A
    int rcnt [N];
    int multi_ready = 0;
    initial for (int i = 0; i < N; i++) rcnt[i] = 0;
    always @(negedge clk) begin
        if ($countones(a.req_ready) > 1) multi_ready++;
        for (int i = 0; i < N; i++)
            if (a.req_ready[i] && a.req_valid[i]) rcnt[i]++;
    end

    // Instance B: load period, data stability, comma-gap and packet-length tracking
    int   b_clk = 0;
    int   b_last = -1;
    int   b_period_bad = 0;
    int   b_stable_bad = 0;
    int   b_gap_bad = 0;
    int   b_len_bad = 0;
    int   b_pkts = 0;
    int   b_commas = 0;
    int   b_bytes = 0;
    logic b_prev_load = 1'b0;
    logic [7:0] b_prev_data = 8'h00;
    always @(negedge clk) begin
        if (rst_nb) begin
            b_clk++;
            if (b_prev_load && b.sym_data !== b_prev_data) b_stable_bad++;
            if (b.sym_load) begin
                if (b_last >= 0 && b_clk - b_last != 10) b_period_bad++;
                b_last = b_clk;
                if (b.sym_k) begin
                    if (b_bytes > 0) begin
                        if (b_bytes != 7) b_len_bad++;
                        b_pkts++;
                        b_bytes = 0;
                    end
                    b_commas++;
                end else begin
                    if (b_commas > 0) begin
                        if (b_commas != 3) b_gap_bad++;
                        b_commas = 0;
                    end
                    b_bytes++;
                end
            end
            b_prev_load = b.sym_load;
            b_prev_data = b.sym_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next sym_load cycle on A (sampled at negedge), bounded
    task automatic next_sym();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a.sym_load && n < 30);
        chk("sym_load_seen", {31'd0, a.sym_load}, 32'd1);
    endtask

    task automatic do_reset(input logic le, input logic [N-1:0] v, input logic [31:0] d);
        rst_n = 1'b0;
        a.link_en = le;
        a.req_valid = v;
        a.req_data = d;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int r0;
    int tot0;
    int g;

    initial begin
        rst_n = 1'b0;
        rst_nb = 1'b0;
        a.link_en = 1'b1;
        a.req_valid = 4'b0100;
        a.req_data = 32'h445A2211;
        b.link_en = 1'b1;
        b.req_valid = 4'b1111;
        b.req_data = 32'h44332211;
        @(negedge clk);

        // Reset values
        chk("rst_sym_data", a.sym_data, 8'hBC);
        chk("rst_sym_k", a.sym_k, 1);
        chk("rst_sym_load", a.sym_load, 0);
        chk("rst_req_ready", a.req_ready, 0);
        chk("rst_grant_id", a.grant_id, 0);
        chk("rst_busy", a.busy, 0);
        chk("rst_pkt_done", a.pkt_done, 0);
        chk("rst_err", a.err_underrun, 0);
        rst_n = 1'b1;
        rst_nb = 1'b1;

        // Test 1: lone requester 2, 0x5A
        next_sym();
        chk("t1_first_k", a.sym_k, 1);
        chk("t1_first_data", a.sym_data, 8'hBC);
        chk("t1_first_busy", a.busy, 0);
        r0 = rcnt[2];
        next_sym();
        chk("t1_grant", a.grant_id, 2);
        chk("t1_busy", a.busy, 1);
        chk("t1_b1_data", a.sym_data, 8'h5A);
        chk("t1_b1_k", a.sym_k, 0);
        for (int i = 2; i <= 7; i++) begin
            next_sym();
            chk("t1_data", a.sym_data, 8'h5A);
            chk("t1_done", a.pkt_done, (i == 7) ? 1 : 0);
        end
        chk("t1_ready_cnt", rcnt[2] - r0, 7);
        next_sym();
        chk("t1_gap_k", a.sym_k, 1);
        chk("t1_gap_busy", a.busy, 0);
        next_sym();
        chk("t1_regrant", a.grant_id, 2);
        chk("t1_regrant_busy", a.busy, 1);
        chk("t1_regrant_k", a.sym_k, 0);

        // Test 2: all four valid, round-robin 0,1,2,3,0
        do_reset(1'b1, 4'b1111, 32'hA3A2A1A0);
        next_sym();
        chk("t2_first_k", a.sym_k, 1);
        for (int p = 0; p < 5; p++) begin
            g = p % 4;
            r0 = rcnt[g];
            for (int i = 1; i <= 7; i++) begin
                next_sym();
                chk("t2_grant", a.grant_id, g);
                chk("t2_data", a.sym_data, 8'hA0 + g);
                chk("t2_k", a.sym_k, 0);
            end
            chk("t2_ready_cnt", rcnt[g] - r0, 7);
            next_sym();
            chk("t2_gap_k", a.sym_k, 1);
            chk("t2_gap_data", a.sym_data, 8'hBC);
        end

        // Test 3: underrun on requester 1 at byte 4, then requester 2
        do_reset(1'b1, 4'b0110, 32'h44332211);
        next_sym();
        r0 = rcnt[1];
        for (int i = 1; i <= 3; i++) begin
            next_sym();
            chk("t3_grant", a.grant_id, 1);
            chk("t3_data", a.sym_data, 8'h22);
        end
        a.req_valid = 4'b0100;
        next_sym();
        chk("t3_abort_k", a.sym_k, 1);
        chk("t3_abort_data", a.sym_data, 8'hBC);
        chk("t3_err", a.err_underrun, 1);
        chk("t3_busy", a.busy, 0);
        chk("t3_ready_cnt", rcnt[1] - r0, 3);
        next_sym();
        chk("t3_next_grant", a.grant_id, 2);
        chk("t3_next_busy", a.busy, 1);
        chk("t3_next_data", a.sym_data, 8'h33);
        chk("t3_err_clear", a.err_underrun, 0);

        // Test 4: link disabled, then cleared mid-packet
        do_reset(1'b0, 4'b1111, 32'h44332211);
        tot0 = rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3];
        for (int i = 0; i < 4; i++) begin
            next_sym();
            chk("t4_off_k", a.sym_k, 1);
            chk("t4_off_busy", a.busy, 0);
        end
        chk("t4_off_ready", rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3] - tot0, 0);
        a.link_en = 1'b1;
        next_sym();
        chk("t4_grant", a.grant_id, 0);
        chk("t4_b1", a.sym_data, 8'h11);
        next_sym();
        a.link_en = 1'b0;
        for (int i = 3; i <= 7; i++) begin
            next_sym();
            chk("t4_data", a.sym_data, 8'h11);
            chk("t4_k", a.sym_k, 0);
            chk("t4_done", a.pkt_done, (i == 7) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            next_sym();
            chk("t4_tail_k", a.sym_k, 1);
            chk("t4_tail_busy", a.busy, 0);
        end
        chk("t4_ready_a0", rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3] - tot0, 7);

        // Test 5: asynchronous reset mid-packet
        do_reset(1'b1, 4'b0100, 32'h445A2211);
        next_sym();
        next_sym();
        next_sym();
        chk("t5_pre_busy", a.busy, 1);
        r0 = rcnt[2];
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_data", a.sym_data, 8'hBC);
        chk("t5_rst_k", a.sym_k, 1);
        chk("t5_rst_busy", a.busy, 0);
        chk("t5_rst_grant", a.grant_id, 0);
        chk("t5_rst_load", a.sym_load, 0);
        chk("t5_rst_ready", a.req_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t5_rst_pops", rcnt[2] - r0, 0);
        rst_n = 1'b1;
        next_sym();
        chk("t5_after_k", a.sym_k, 1);
        chk("t5_after_busy", a.busy, 0);
        next_sym();
        chk("t5_after_grant", a.grant_id, 2);
        chk("t5_after_gbusy", a.busy, 1);
        chk("t5_after_pops", rcnt[2] - r0, 1);

        // Test 6: three-comma gap instance and global invariants
        chk("t6_gap", b_gap_bad, 0);
        chk("t6_len", b_len_bad, 0);
        chk("t6_period", b_period_bad, 0);
        chk("t6_stable", b_stable_bad, 0);
        chk("t6_pkts", {31'd0, b_pkts >= 5}, 1);
        chk("onehot_ready", multi_ready, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
